// File: rtl/count_down_timer_if.sv
// Control/status bundle for the loadable down-counter timer.
// Master drives the controls, slave is the timer itself.
interface count_down_timer_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             stop_i;
    logic             en_i;
    logic             auto_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i,
        output stop_i,
        output en_i,
        output auto_i,
        output data_i,
        input  count_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  stop_i,
        input  en_i,
        input  auto_i,
        input  data_i,
        output count_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/count_down_timer.sv
// Loadable down-counter with start/stop, busy, one-cycle done
// pulse and optional auto-reload for periodic strobes.
module count_down_timer #(
    parameter int WIDTH = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    count_down_timer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;

    // Timer FSM: STOP beats START beats tick; done is a one-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        reload_q <= bus.data_i;
                        count_q  <= bus.data_i;
                        if (bus.data_i != ZERO) begin
                            state_q <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop_i) begin
                        state_q <= IDLE;
                    end else if (bus.start_i) begin
                        reload_q <= bus.data_i;
                        count_q  <= bus.data_i;
                        if (bus.data_i == ZERO) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (bus.en_i) begin
                        if (count_q > ONE) begin
                            count_q <= count_q - ONE;
                        end else begin
                            done_q <= 1'b1;
                            if (bus.auto_i) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= ZERO;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count_o = count_q;
    assign bus.busy_o  = (state_q == RUN);
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_count_down_timer;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    int   m_cnt;
    int   m_rel;
    bit   m_run;
    bit   m_done;

    always #5 clk = ~clk;

    count_down_timer_if #(.WIDTH(8)) bus ();

    count_down_timer #(.WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    function automatic logic [9:0] expv();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {c, m_run, m_done};
    endfunction

    function automatic logic [9:0] actv();
        return {bus.count_o, bus.busy_o, bus.done_o};
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_rel  = 0;
        m_run  = 0;
        m_done = 0;
    endtask

    // Apply the documented timer rules for one rising edge.
    task automatic model_edge();
        m_done = 0;
        if (bus.stop_i && m_run) begin
            m_run = 0;
        end else if (bus.start_i) begin
            m_rel  = int'(bus.data_i);
            m_cnt  = m_rel;
            m_run  = (m_rel != 0);
            m_done = (m_rel == 0);
        end else if (m_run && bus.en_i) begin
            if (m_cnt == 1) begin
                m_done = 1;
                if (bus.auto_i) begin
                    m_cnt = m_rel;
                end else begin
                    m_cnt = 0;
                    m_run = 0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i = 0;
        bus.stop_i  = 0;
        bus.en_i    = 0;
        bus.auto_i  = 0;
        bus.data_i  = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        #12;
        tests++;
        if (actv() !== 10'd0) begin
            fails++;
            $display("FAIL reset_init got=%h want=%h", actv(), 10'd0);
        end
        rst = 0;
        bus.start_i = 1;
        bus.data_i  = 8'd5;
        step();
        bus.start_i = 0;
        tests++;
        if (actv() !== {8'd5, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_load got=%h want=%h",
                     actv(), {8'd5, 1'b1, 1'b0});
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        tests++;
        if (actv() !== 10'd0) begin
            fails++;
            $display("FAIL reset_async got=%h want=%h", actv(), 10'd0);
        end
        step();
        rst = 0;
    endtask

    task automatic test_oneshot();
        logic [9:0] want [4];
        want[0] = {8'd3, 1'b1, 1'b0};
        want[1] = {8'd2, 1'b1, 1'b0};
        want[2] = {8'd1, 1'b1, 1'b0};
        want[3] = {8'd0, 1'b0, 1'b1};
        idle_inputs();
        bus.start_i = 1;
        bus.data_i  = 8'd3;
        bus.en_i    = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.start_i = 0;
            tests++;
            if (actv() !== want[i] || actv() !== expv()) begin
                fails++;
                $display("FAIL oneshot[%0d] got=%h want=%h",
                         i, actv(), want[i]);
            end
        end
        step();
        tests++;
        if (actv() !== 10'd0) begin
            fails++;
            $display("FAIL oneshot_after got=%h want=%h", actv(), 10'd0);
        end
    endtask

    task automatic test_auto_gate();
        int last = -1;
        int ndone = 0;
        idle_inputs();
        bus.auto_i  = 1;
        bus.start_i = 1;
        bus.data_i  = 8'd4;
        step();
        bus.start_i = 0;
        for (int i = 0; i < 24; i++) begin
            bus.en_i = (i % 2 == 1);
            step();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL auto_model[%0d] got=%h want=%h",
                         i, actv(), expv());
            end
            if (bus.done_o) begin
                ndone++;
                tests++;
                if (bus.count_o !== 8'd4 ||
                    (last >= 0 && i - last != 8)) begin
                    fails++;
                    $display("FAIL auto_period got=%0d/%0d want=4/8",
                             bus.count_o, i - last);
                end
                last = i;
            end
        end
        tests++;
        if (ndone != 3) begin
            fails++;
            $display("FAIL auto_pulses got=%0d want=3", ndone);
        end
        bus.stop_i = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_stop_vs_expiry();
        idle_inputs();
        bus.start_i = 1;
        bus.data_i  = 8'd2;
        step();
        bus.start_i = 0;
        bus.en_i    = 1;
        step();
        bus.stop_i = 1;
        step();
        tests++;
        if (actv() !== {8'd1, 1'b0, 1'b0} || actv() !== expv()) begin
            fails++;
            $display("FAIL stop_expiry got=%h want=%h",
                     actv(), {8'd1, 1'b0, 1'b0});
        end
        idle_inputs();
    endtask

    task automatic test_restart();
        idle_inputs();
        bus.start_i = 1;
        bus.data_i  = 8'd5;
        step();
        bus.start_i = 0;
        bus.en_i    = 1;
        repeat (3) step();
        tests++;
        if (bus.count_o !== 8'd2) begin
            fails++;
            $display("FAIL restart_pre got=%0d want=2", bus.count_o);
        end
        bus.start_i = 1;
        bus.data_i  = 8'hFF;
        step();
        tests++;
        if (actv() !== {8'hFF, 1'b1, 1'b0} || actv() !== expv()) begin
            fails++;
            $display("FAIL restart got=%h want=%h",
                     actv(), {8'hFF, 1'b1, 1'b0});
        end
        idle_inputs();
        bus.stop_i = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_zero_load();
        idle_inputs();
        bus.start_i = 1;
        bus.data_i  = 8'd0;
        bus.en_i    = 1;
        step();
        bus.start_i = 0;
        tests++;
        if (actv() !== {8'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL zero_pulse got=%h want=%h",
                     actv(), {8'd0, 1'b0, 1'b1});
        end
        step();
        tests++;
        if (actv() !== 10'd0) begin
            fails++;
            $display("FAIL zero_after got=%h want=%h", actv(), 10'd0);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.start_i = ($urandom_range(0, 15) == 0);
            bus.stop_i  = ($urandom_range(0, 31) == 0);
            bus.en_i    = ($urandom_range(0, 3) != 0);
            bus.auto_i  = ($urandom_range(0, 1) == 1);
            bus.data_i  = ($urandom_range(0, 7) == 0) ?
                          8'd0 : 8'($urandom_range(1, 9));
            step();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL random[%0d] got=%h want=%h",
                         i, actv(), expv());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_gate();
        test_stop_vs_expiry();
        test_restart();
        test_zero_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
